aes128_inv_cipher_ctrl: RTL and testbench

Iterative AES-128 inverse-cipher sequencer: accepts one 128-bit ciphertext block, runs the initial AddRoundKey plus ten decryption rounds at one round per clock, and returns the plaintext over a valid/ready handshake. It owns the round counter, the round-key index toward the external expanded-key store, and the state register. The inverse-round datapath is built around the existing `inverseMixColumns` module.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_inv_round.sv | 34 +++
 rtl/inverseMixColumns.sv | 50 +++++
 rtl/aes128_inv_cipher_ctrl.sv | 95 +++++++++
 tb/tb_aes128_inv_cipher_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 decryption constants, FSM encoding and byte-level helpers.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam logic [3:0] KEY_LAST = 4'(AES_NR);
    localparam logic [3:0] RND_FIRST = 4'(AES_NR - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_e;

    // Entry b sits at index b; entry 0 is the most significant byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Byte (row r, column c) lives at index 4c+r, MSB first.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] =
                    s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] next_st
);

    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] t;
    logic [127:0] mc;

    assign sr = inv_shift_rows(st);

    always_comb begin
        sb = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127 - 8*i -: 8] = inv_sbox(sr[127 - 8*i -: 8]);
        end
    end

    assign t = sb ^ round_key;

    inverseMixColumns u_imc (
        .data_i (t),
        .data_o (mc)
    );

    assign next_st = last ? t : mc;

endmodule

// File: rtl/inverseMixColumns.sv
// InvMixColumns over all four columns of a column-major AES state.
module inverseMixColumns (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using a shared xtime chain.
    function automatic logic [7:0] gm(input logic [7:0] b,
                                      input logic [3:0] k);
        logic [7:0] b2;
        logic [7:0] b4;
        logic [7:0] b8;
        logic [7:0] r;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        r = k[0] ? b : 8'h00;
        if (k[1]) r = r ^ b2;
        if (k[2]) r = r ^ b4;
        if (k[3]) r = r ^ b8;
        return r;
    endfunction

    always_comb begin
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        data_o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = data_i[127 - 32*c -: 8];
            a1 = data_i[119 - 32*c -: 8];
            a2 = data_i[111 - 32*c -: 8];
            a3 = data_i[103 - 32*c -: 8];
            data_o[127 - 32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb)
                                    ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
            data_o[119 - 32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he)
                                    ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
            data_o[111 - 32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9)
                                    ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
            data_o[103 - 32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd)
                                    ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
        end
    end

endmodule

// File: rtl/aes128_inv_cipher_ctrl.sv
// Iterative AES-128 decryptor: one inverse round per clock, valid/ready
// on both sides, round-key index driven toward an external key store.
module aes128_inv_cipher_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    state_e       state_q;
    state_e       state_d;
    logic [127:0] st_q;
    logic [127:0] st_d;
    logic [3:0]   rnd_q;
    logic [3:0]   rnd_d;
    logic [127:0] round_next;

    aes_inv_round u_round (
        .st        (st_q),
        .round_key (round_key),
        .last      (rnd_q == 4'd0),
        .next_st   (round_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        key_idx   = KEY_LAST;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = in_data ^ round_key;
                    rnd_d   = RND_FIRST;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                busy    = 1'b1;
                key_idx = rnd_q;
                st_d    = round_next;
                if (rnd_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                // A new block may ride on the output handshake cycle.
                if (out_ready) begin
                    if (in_valid) begin
                        st_d    = in_data ^ round_key;
                        rnd_d   = RND_FIRST;
                        state_d = S_ROUND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data = st_q;

endmodule

// File: tb/tb_aes128_inv_cipher_ctrl.sv
// Bench: a forward AES-128 model encrypts plaintexts; the DUT must return them.
module tb_aes128_inv_cipher_ctrl;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [7:0]   sbox [256];
    logic [127:0] rk [16];
    int           n_cmp;
    int           n_bad;

    aes128_inv_cipher_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    assign round_key = rk[key_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse, then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                b = {b[6:0], b[7]};
                s = s ^ b;
            end
            sbox[x] = s ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]],
                     sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++) begin
                for (int w = 0; w < 4; w++) begin
                    s[4*c + w] = t[4*((c + w) % 4) + w];
                end
            end
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c];
                    a1 = s[4*c+1];
                    a2 = s[4*c+2];
                    a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) begin
                s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ov"}, 128'(out_valid), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_ir"}, 128'(in_ready), 128'(1));
        chk({tag, "_kidx"}, 128'(key_idx), 128'(10));
        chk({tag, "_od"}, out_data, 128'h0);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            cyc();
            n++;
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] ct,
                             input logic [127:0] pt);
        int n;
        in_data   = ct;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        chk({tag, "_rdy"}, 128'(in_ready), 128'(1));
        cyc();
        in_valid = 1'b0;
        wait_out(n);
        chk({tag, "_lat"}, 128'(n), 128'(10));
        chk({tag, "_pt"}, out_data, pt);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        #1;
        chk({tag, "_idle"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        logic [127:0] key;
        logic [127:0] pt1;
        logic [127:0] pt2;
        int           n;

        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) rk[i] = '0;
        build_sbox();
        expand(KEY_C1);

        cyc();
        cyc();
        chk_reset("rst");
        rst = 1'b0;

        // FIPS-197 C.1 with key-index trace
        in_data  = CT_C1;
        in_valid = 1'b1;
        #1;
        chk("c1_rdy", 128'(in_ready), 128'(1));
        chk("c1_kidx_acc", 128'(key_idx), 128'(10));
        cyc();
        in_valid = 1'b0;
        for (int k = 9; k >= 0; k--) begin
            chk($sformatf("c1_kidx%0d", k), 128'(key_idx), 128'(k));
            chk($sformatf("c1_busy%0d", k), 128'(busy), 128'(1));
            chk($sformatf("c1_ov%0d", k), 128'(out_valid), 128'(0));
            cyc();
        end
        chk("c1_valid", 128'(out_valid), 128'(1));
        chk("c1_pt", out_data, PT_C1);
        chk("c1_kidx_done", 128'(key_idx), 128'(10));
        chk("c1_busy_done", 128'(busy), 128'(0));

        // Backpressure in DONE
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_ov%0d", k), 128'(out_valid), 128'(1));
            chk($sformatf("bp_od%0d", k), out_data, PT_C1);
            chk($sformatf("bp_ir%0d", k), 128'(in_ready), 128'(0));
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ir", 128'(in_ready), 128'(1));
        cyc();
        out_ready = 1'b0;
        #1;
        chk("bp_after_ov", 128'(out_valid), 128'(0));
        chk("bp_after_ir", 128'(in_ready), 128'(1));

        // Random keys and plaintexts
        for (int k = 0; k < 4; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt1 = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            run_block($sformatf("rnd%0d", k), aes_enc(pt1), pt1);
        end

        // Back-to-back with in_valid held
        key = {$urandom, $urandom, $urandom, $urandom};
        pt1 = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        expand(key);
        in_data   = aes_enc(pt1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_data = aes_enc(pt2);
        for (int k = 0; k < 10; k++) cyc();
        chk("b2b_ov1", 128'(out_valid), 128'(1));
        chk("b2b_pt1", out_data, pt1);
        chk("b2b_ir1", 128'(in_ready), 128'(1));
        cyc();
        in_valid = 1'b0;
        #1;
        chk("b2b_busy2", 128'(busy), 128'(1));
        chk("b2b_kidx2", 128'(key_idx), 128'(9));
        for (int k = 0; k < 10; k++) cyc();
        chk("b2b_ov2", 128'(out_valid), 128'(1));
        chk("b2b_pt2", out_data, pt2);
        cyc();
        out_ready = 1'b0;
        #1;
        chk("b2b_end_ov", 128'(out_valid), 128'(0));

        // Garbage offered during ROUND
        expand(KEY_C1);
        in_data  = CT_C1;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("grb_ir", 128'(in_ready), 128'(0));
        cyc();
        cyc();
        in_valid = 1'b0;
        wait_out(n);
        chk("grb_ov", 128'(out_valid), 128'(1));
        chk("grb_pt", out_data, PT_C1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Reset at round 5, then a fresh block
        in_data  = CT_C1;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        chk("ab_kidx5", 128'(key_idx), 128'(5));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk_reset("ab");
        n = 0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) n++;
            cyc();
        end
        chk("ab_noval", 128'(n), 128'(0));
        run_block("fresh", CT_C1, PT_C1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
